// File: rtl/palindrome_pkg.sv
// -----------------------------------------------------------------------------
// palindrome_pkg
// Shared definitions for the sequential palindrome checker:
//   - radix (mode) encodings presented on the checker's mode input
//   - controller state enumeration
//   - dec_digits(): number of BCD digits needed to hold a WIDTH-bit value
// -----------------------------------------------------------------------------
package palindrome_pkg;

  localparam logic [1:0] MODE_BIN = 2'b00;
  localparam logic [1:0] MODE_DEC = 2'b01;
  localparam logic [1:0] MODE_HEX = 2'b10;
  localparam logic [1:0] MODE_RSV = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    CONVERT,
    LENGTH,
    COMPARE,
    DONE
  } state_e;

  // ceil(width * log10(2)); log10(2) approximated as 0.30103, which is exact
  // enough for the whole 4..32 operand range (width*log10(2) is never an
  // integer there, so rounding up is always correct).
  function automatic int dec_digits(input int width);
    return (width * 30103 + 99999) / 100000;
  endfunction

endpackage

// File: rtl/bin2bcd_serial.sv
// -----------------------------------------------------------------------------
// bin2bcd_serial
// Iterative double-dabble binary-to-BCD converter, one operand bit per cycle.
//
// Ports:
//   clk    in   rising-edge clock
//   rst    in   asynchronous active-high reset
//   load   in   capture bin and start a conversion
//   bin    in   WIDTH-bit unsigned operand
//   bcd    out  4*DIGITS-bit packed BCD result, digit 0 in bits [3:0]
//   valid  out  high once all WIDTH bits have been shifted in; held until the
//               next load
//
// The load cycle already performs the first iteration (an all-zero BCD
// register needs no +3 correction), so the remaining WIDTH-1 iterations
// follow and valid rises WIDTH-1 cycles after the load edge. Seen from the
// controller this is exactly WIDTH cycles spent waiting on valid.
// -----------------------------------------------------------------------------
module bin2bcd_serial
  import palindrome_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int DIGITS = dec_digits(WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [WIDTH-1:0]      bin,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  valid
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0]    shift_reg;
  logic [4*DIGITS-1:0] bcd_reg;
  logic [CW-1:0]       cnt_reg;
  logic                run_reg;
  logic                valid_reg;

  // Corrected digits before the shift. The most significant bit of the top
  // digit is shifted out and is always zero for an in-range operand, so only
  // the low three bits of that digit are kept.
  logic [4*DIGITS-2:0] adj;

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_adj
      if (gi == DIGITS - 1) begin : g_top
        assign adj[4*gi +: 3] = bcd_reg[4*gi +: 3] +
                                ((bcd_reg[4*gi +: 4] >= 4'd5) ? 3'd3 : 3'd0);
      end else begin : g_mid
        assign adj[4*gi +: 4] = (bcd_reg[4*gi +: 4] >= 4'd5) ?
                                (bcd_reg[4*gi +: 4] + 4'd3) : bcd_reg[4*gi +: 4];
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_reg <= '0;
      bcd_reg   <= '0;
      cnt_reg   <= '0;
      run_reg   <= 1'b0;
      valid_reg <= 1'b0;
    end else if (load) begin
      shift_reg <= bin << 1;
      bcd_reg   <= (4*DIGITS)'(bin[WIDTH-1]);
      cnt_reg   <= CW'(1);
      run_reg   <= 1'b1;
      valid_reg <= 1'b0;
    end else if (run_reg) begin
      shift_reg <= shift_reg << 1;
      bcd_reg   <= {adj, shift_reg[WIDTH-1]};
      cnt_reg   <= cnt_reg + 1'b1;
      if (cnt_reg == CW'(WIDTH - 1)) begin
        run_reg   <= 1'b0;
        valid_reg <= 1'b1;
      end
    end
  end

  assign bcd   = bcd_reg;
  assign valid = valid_reg;

endmodule

// File: rtl/seq_palindrome_checker.sv
// -----------------------------------------------------------------------------
// seq_palindrome_checker
// Multi-cycle palindrome checker for an unsigned WIDTH-bit operand in binary,
// decimal or (optionally) hexadecimal radix, with a start/done handshake.
//
// Ports:
//   clk            in   rising-edge clock
//   rst            in   asynchronous active-high reset
//   start          in   request, sampled only while idle
//   number         in   WIDTH-bit operand, captured on an accepted start
//   mode           in   2'b00 binary, 2'b01 decimal, 2'b10 hex, 2'b11 reserved
//   busy           out  high from the cycle after accept through the done cycle
//   done           out  one-cycle result-valid pulse
//   is_palindrome  out  result, held until the next accepted start
//   err            out  unsupported mode flag, held like is_palindrome
//
// Build option:
//   PALINDROME_HEX_MODE_EN  when defined, mode 2'b10 checks hex nibbles;
//                           otherwise 2'b10 is rejected like 2'b11.
//
// Flow: decimal operands are first converted by bin2bcd_serial (CONVERT),
// then LENGTH finds the most significant nonzero digit so leading zeros never
// take part, and COMPARE walks digit pairs inward one pair per cycle, leaving
// on the first mismatch. All outputs come straight from flops.
// -----------------------------------------------------------------------------
module seq_palindrome_checker
  import palindrome_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] number,
  input  logic [1:0]       mode,
  output logic             busy,
  output logic             done,
  output logic             is_palindrome,
  output logic             err
);

  localparam int DIGITS = dec_digits(WIDTH);
  // Digit index width; the digit table is padded to a power of two so any
  // index value selects a defined (zero) digit.
  localparam int IW    = $clog2(WIDTH + 1);
  localparam int NSLOT = 1 << IW;

  state_e           state_reg, state_next;
  logic [WIDTH-1:0] operand_reg;
  logic [1:0]       mode_reg;
  logic [IW-1:0]    lo_reg, lo_next;
  logic [IW-1:0]    hi_reg, hi_next;
  logic             busy_reg, busy_next;
  logic             done_reg, done_next;
  logic             pal_reg, pal_next;
  logic             err_reg, err_next;

  logic                accept;
  logic                bcd_load;
  logic [4*DIGITS-1:0] bcd;
  logic                bcd_valid;

  logic [3:0]    bin_dig [NSLOT];
  logic [3:0]    dec_dig [NSLOT];
  logic [3:0]    dig     [NSLOT];
  logic [IW-1:0] len;
  logic          pair_done;

  assign accept   = (state_reg == IDLE) && start;
  assign bcd_load = accept && (mode == MODE_DEC);

  bin2bcd_serial #(
    .WIDTH  (WIDTH),
    .DIGITS (DIGITS)
  ) u_bin2bcd (
    .clk   (clk),
    .rst   (rst),
    .load  (bcd_load),
    .bin   (number),
    .bcd   (bcd),
    .valid (bcd_valid)
  );

  // ---------------------------------------------------------------------------
  // Digit tables, least significant digit at index 0, zero beyond the radix's
  // natural digit count.
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < NSLOT; gi++) begin : g_dig
      if (gi < WIDTH) begin : g_bin
        assign bin_dig[gi] = {3'b000, operand_reg[gi]};
      end else begin : g_bin_pad
        assign bin_dig[gi] = 4'd0;
      end
      if (gi < DIGITS) begin : g_dec
        assign dec_dig[gi] = bcd[4*gi +: 4];
      end else begin : g_dec_pad
        assign dec_dig[gi] = 4'd0;
      end
    end
  endgenerate

`ifdef PALINDROME_HEX_MODE_EN
  localparam int NHEX = (WIDTH + 3) / 4;

  logic [4*NHEX-1:0] operand_pad;
  logic [3:0]        hex_dig [NSLOT];

  // A partial top nibble is zero-extended so it still reads as one digit.
  assign operand_pad = (4*NHEX)'(operand_reg);

  generate
    for (gi = 0; gi < NSLOT; gi++) begin : g_hex
      if (gi < NHEX) begin : g_nib
        assign hex_dig[gi] = operand_pad[4*gi +: 4];
      end else begin : g_nib_pad
        assign hex_dig[gi] = 4'd0;
      end
    end
  endgenerate
`endif

  always_comb begin
    for (int i = 0; i < NSLOT; i++) begin
      dig[i] = bin_dig[i];
      if (mode_reg == MODE_DEC) begin
        dig[i] = dec_dig[i];
      end
`ifdef PALINDROME_HEX_MODE_EN
      if (mode_reg == MODE_HEX) begin
        dig[i] = hex_dig[i];
      end
`endif
    end
  end

  // Significant length: one past the highest nonzero digit, 1 for a zero value.
  always_comb begin
    len = IW'(1);
    for (int i = 0; i < NSLOT; i++) begin
      if (dig[i] != 4'd0) begin
        len = IW'(i + 1);
      end
    end
  end

  // lo+1 >= hi-1 rewritten as lo+2 >= hi so hi never has to go below zero
  // (L=1 starts with lo=hi=0).
  assign pair_done = (({1'b0, lo_reg} + (IW+1)'(2)) >= {1'b0, hi_reg});

  // ---------------------------------------------------------------------------
  // Controller
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      operand_reg <= '0;
      mode_reg    <= MODE_BIN;
      lo_reg      <= '0;
      hi_reg      <= '0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      pal_reg     <= 1'b0;
      err_reg     <= 1'b0;
    end else begin
      state_reg <= state_next;
      lo_reg    <= lo_next;
      hi_reg    <= hi_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
      pal_reg   <= pal_next;
      err_reg   <= err_next;
      if (accept) begin
        operand_reg <= number;
        mode_reg    <= mode;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    lo_next    = lo_reg;
    hi_next    = hi_reg;
    pal_next   = pal_reg;
    err_next   = err_reg;

    unique case (state_reg)
      IDLE: begin
        if (start) begin
          pal_next = 1'b0;
          err_next = 1'b0;
          if (mode == MODE_DEC) begin
            state_next = CONVERT;
          end else if (mode == MODE_BIN) begin
            state_next = LENGTH;
`ifdef PALINDROME_HEX_MODE_EN
          end else if (mode == MODE_HEX) begin
            state_next = LENGTH;
`endif
          end else begin
            err_next   = 1'b1;
            state_next = DONE;
          end
        end
      end

      CONVERT: begin
        if (bcd_valid) begin
          state_next = LENGTH;
        end
      end

      LENGTH: begin
        lo_next    = '0;
        hi_next    = len - 1'b1;
        state_next = COMPARE;
      end

      COMPARE: begin
        lo_next = lo_reg + 1'b1;
        hi_next = hi_reg - 1'b1;
        if (dig[lo_reg] != dig[hi_reg]) begin
          pal_next   = 1'b0;
          state_next = DONE;
        end else if (pair_done) begin
          pal_next   = 1'b1;
          state_next = DONE;
        end
      end

      DONE: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Output flops are loaded from the next state so they line up with it.
  assign busy_next = (state_next != IDLE);
  assign done_next = (state_next == DONE);

  assign busy          = busy_reg;
  assign done          = done_reg;
  assign is_palindrome = pal_reg;
  assign err           = err_reg;

endmodule

// File: tb/tb_seq_palindrome_checker.sv
// -----------------------------------------------------------------------------
// tb_seq_palindrome_checker
// Self-checking bench: directed cases plus randomized operands/modes, checked
// against a digit-list reference model (repeated division by the radix).
// -----------------------------------------------------------------------------
module tb_seq_palindrome_checker;

  localparam int WIDTH = 16;

  logic             clk;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] number;
  logic [1:0]       mode;
  logic             busy;
  logic             done;
  logic             is_palindrome;
  logic             err;

  int n_checks = 0;
  int n_errors = 0;

  seq_palindrome_checker #(.WIDTH(WIDTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .number        (number),
    .mode          (mode),
    .busy          (busy),
    .done          (done),
    .is_palindrome (is_palindrome),
    .err           (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: digits by repeated division, compare outer pairs inward.
  task automatic ref_model(input logic [WIDTH-1:0] num, input logic [1:0] md,
                           output bit pal, output bit e, output int lat);
    int radix;
    int v;
    int c;
    int digs[$];
    bit hex_ok;
`ifdef PALINDROME_HEX_MODE_EN
    hex_ok = 1'b1;
`else
    hex_ok = 1'b0;
`endif
    if (md == 2'b11 || (md == 2'b10 && !hex_ok)) begin
      pal = 1'b0;
      e   = 1'b1;
      lat = 1;
      return;
    end
    radix = (md == 2'b00) ? 2 : (md == 2'b01) ? 10 : 16;
    v = int'(num);
    do begin
      digs.push_back(v % radix);
      v = v / radix;
    end while (v != 0);
    pal = 1'b1;
    e   = 1'b0;
    c   = 0;
    for (int k = 0; k < digs.size() / 2; k++) begin
      c++;
      if (digs[k] != digs[digs.size() - 1 - k]) begin
        pal = 1'b0;
        break;
      end
    end
    if (c == 0) c = 1;
    lat = ((md == 2'b01) ? WIDTH : 0) + 1 + c + 1;
  endtask

  // Builds a palindrome in the given radix that fits in WIDTH bits.
  function automatic logic [WIDTH-1:0] make_pal(input logic [1:0] md);
    int radix;
    int maxlen;
    int len;
    int d[16];
    int v;
    radix  = (md == 2'b01) ? 10 : (md == 2'b10) ? 16 : 2;
    maxlen = (md == 2'b01) ? 4 : (md == 2'b10) ? 4 : 16;
    len    = int'($urandom_range(maxlen, 1));
    for (int i = 0; i < (len + 1) / 2; i++) begin
      d[i] = (i == 0) ? int'($urandom_range(radix - 1, 1)) : int'($urandom_range(radix - 1, 0));
      d[len - 1 - i] = d[i];
    end
    v = 0;
    for (int i = 0; i < len; i++) v = v * radix + d[i];
    return WIDTH'(v);
  endfunction

  // One transaction: start in the first idle cycle, wait for done (bounded),
  // check result, error flag, latency and busy. Optionally pulse start with
  // a different operand while the unit is busy.
  task automatic run_op(input logic [WIDTH-1:0] num, input logic [1:0] md, input bit inject);
    bit exp_pal;
    bit exp_err;
    int exp_lat;
    int cyc;
    ref_model(num, md, exp_pal, exp_err, exp_lat);
    @(negedge clk);
    check_eq("idle_done", 32'(done), 32'd0);
    check_eq("idle_busy", 32'(busy), 32'd0);
    start  = 1'b1;
    number = num;
    mode   = md;
    @(negedge clk);
    cyc    = 1;
    start  = 1'b0;
    number = WIDTH'($urandom);
    mode   = 2'($urandom);
    check_eq("busy_first", 32'(busy), 32'd1);
    while (done !== 1'b1 && cyc < 200) begin
      start = inject && (cyc == 2);
      if (start) begin
        number = ~num;
        mode   = md;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    check_eq("done_seen", 32'(done), 32'd1);
    check_eq("latency", 32'(cyc), 32'(exp_lat));
    check_eq("is_palindrome", 32'(is_palindrome), 32'(exp_pal));
    check_eq("err", 32'(err), 32'(exp_err));
    check_eq("busy_done", 32'(busy), 32'd1);
    $display("op num=%h mode=%0d inject=%0b pal=%0b err=%0b latency=%0d (model pal=%0b err=%0b latency=%0d)",
             num, md, inject, is_palindrome, err, cyc, exp_pal, exp_err, exp_lat);
  endtask

  initial begin
    int seen;
    logic [1:0] md;
    logic [WIDTH-1:0] num;

    rst    = 1'b1;
    start  = 1'b0;
    number = '0;
    mode   = 2'b00;
    repeat (3) @(negedge clk);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_pal",  32'(is_palindrome), 32'd0);
    check_eq("rst_err",  32'(err), 32'd0);
    $display("reset state checked");
    rst = 1'b0;

    // Directed cases.
    run_op(16'h8001, 2'b00, 1'b0);
    run_op(16'h8002, 2'b00, 1'b0);
    run_op(16'd12321, 2'b01, 1'b0);
    run_op(16'd65535, 2'b01, 1'b0);
    run_op(16'd121, 2'b01, 1'b0);
    run_op(16'h0005, 2'b00, 1'b0);
    for (int m = 0; m < 4; m++) run_op(16'h0000, 2'(m), 1'b0);
    run_op(16'hABBA, 2'b10, 1'b0);
    run_op(16'hABCA, 2'b10, 1'b0);
    run_op(16'h1234, 2'b11, 1'b0);
    run_op(16'd12321, 2'b01, 1'b1);
    run_op(16'd1221, 2'b01, 1'b1);

    // Randomized operands, about half constructed as palindromes.
    for (int t = 0; t < 40; t++) begin
      md  = 2'($urandom_range(3, 0));
      num = ($urandom_range(1, 0) == 1) ? make_pal(md) : WIDTH'($urandom);
      run_op(num, md, 1'($urandom_range(1, 0)));
    end

    // Reset during CONVERT.
    @(negedge clk);
    start  = 1'b1;
    number = 16'd4321;
    mode   = 2'b01;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check_eq("busy_before_rst", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    check_eq("midrst_busy", 32'(busy), 32'd0);
    check_eq("midrst_done", 32'(done), 32'd0);
    check_eq("midrst_pal",  32'(is_palindrome), 32'd0);
    check_eq("midrst_err",  32'(err), 32'd0);
    @(negedge clk);
    rst  = 1'b0;
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (done === 1'b1) seen++;
    end
    check_eq("no_done_after_rst", 32'(seen), 32'd0);
    $display("mid-operation reset checked, done pulses after reset=%0d", seen);
    run_op(16'd1221, 2'b01, 1'b0);
    run_op(16'd4321, 2'b01, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
